// File: rtl/ysyx_25020047_exu_pkg.sv
// Shared types for the NPC execute unit: opcodes, FSM states, write-back/memory intent flags.
package ysyx_25020047_exu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu,
        OpPassb, OpJalr, OpLoad, OpStore,
        OpMul, OpMulh, OpMulhu, OpMulhsu, OpDiv, OpDivu, OpRem, OpRemu
    } op_e;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    typedef struct packed {
        logic reg_wen;
        logic mem_rd;
        logic mem_wr;
        logic illegal;
    } flags_t;

    // Sliced down to XLEN by users; divide-by-zero quotient is all ones.
    localparam logic [63:0] DIV_ZERO_Q  = '1;
    localparam logic [63:0] DIV_OVF_REM = '0;

    function automatic logic is_muldiv(logic [OP_W-1:0] op);
        return op inside {OpMul, OpMulh, OpMulhu, OpMulhsu, OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

endpackage

// File: rtl/ysyx_25020047_exu_mc_if.sv
// IDU -> EXU -> LSU/WBU handshake bundle; master drives operands, slave is the EXU.
interface ysyx_25020047_exu_mc_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
);
    import ysyx_25020047_exu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_reg_wen;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic            out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd,
               out_reg_wen, out_mem_rd, out_mem_wr, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd,
               out_reg_wen, out_mem_rd, out_mem_wr, out_illegal
    );

endinterface

// File: rtl/ysyx_25020047_muldiv_iter.sv
// Iterative M-extension unit: shift-add multiply / restoring divide on magnitudes, XLEN steps,
// sign fixup applied combinationally on the final result.
module ysyx_25020047_muldiv_iter
    import ysyx_25020047_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] ITERS = CW'(XLEN);

    logic            busy_q, busy_d, neg_q, neg_d, zero_q, zero_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    // x: multiplicand (mul) or dividend/quotient shifter (div); acc: product or remainder
    logic [2*XLEN-1:0] x_q, x_d, acc_q, acc_d;
    logic [XLEN-1:0]   y_q, y_d;

    logic            a_sgn, b_sgn, is_div;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem;
    logic [XLEN:0]   rem_sh, diff;
    logic [2*XLEN-1:0] prod;

    assign a_sgn  = a[XLEN-1] && (op inside {OpMulh, OpMulhsu, OpDiv, OpRem});
    assign b_sgn  = b[XLEN-1] && (op inside {OpMulh, OpDiv, OpRem});
    assign a_mag  = a_sgn ? -a : a;
    assign b_mag  = b_sgn ? -b : b;
    assign is_div = op_q inside {OpDiv, OpDivu, OpRem, OpRemu};
    assign rem_sh = {acc_q[XLEN-1:0], x_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, y_q};
    assign done   = busy_q && (cnt_q == '0);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        x_d    = x_q;
        y_d    = y_q;
        acc_d  = acc_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = ITERS;
            op_d   = op;
            neg_d  = (op == OpRem) ? a_sgn : (a_sgn ^ b_sgn);
            zero_d = (b == '0);
            x_d    = {{XLEN{1'b0}}, a_mag};
            y_d    = b_mag;
            acc_d  = '0;
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (is_div) begin
                x_d   = {x_q[2*XLEN-1:XLEN], x_q[XLEN-2:0], ~diff[XLEN]};
                acc_d = {acc_q[2*XLEN-1:XLEN], diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]};
            end else begin
                if (y_q[0]) acc_d = acc_q + x_q;
                x_d = x_q << 1;
                y_d = y_q >> 1;
            end
        end
    end

    // MIN / -1 needs no special case: |MIN| / 1 negated wraps back to MIN, remainder 0.
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -x_q[XLEN-1:0] : x_q[XLEN-1:0];
        rem    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        result = '0;
        case (op_q)
            OpMul:                     result = prod[XLEN-1:0];
            OpMulh, OpMulhu, OpMulhsu: result = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             result = zero_q ? DIV_ZERO_Q[XLEN-1:0] : quo;
            OpRem, OpRemu:             result = rem;
            default:                   result = '0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/ysyx_25020047_exu_mc.sv
// NPC execute unit: single-cycle ALU plus optional iterative mul/div, registered result.
// Define YSYX_25020047_EXU_MULDIV_EN to build the M-extension path; otherwise M ops are illegal.
module ysyx_25020047_exu_mc
    import ysyx_25020047_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input logic                   clock,
    input logic                   rst_n,
    ysyx_25020047_exu_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d, alu_res, sum;
    logic [RD_W-1:0] rd_q, rd_d;
    flags_t          flags_q, flags_d, alu_flags;
    logic [SHW-1:0]  sh;
    logic            accept;

    assign sh  = bus.in_b[SHW-1:0];
    assign sum = bus.in_a + bus.in_b;

    always_comb begin
        alu_res   = '0;
        alu_flags = '{reg_wen: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
        case (bus.in_op)
            OpAdd:   alu_res = sum;
            OpSub:   alu_res = bus.in_a - bus.in_b;
            OpAnd:   alu_res = bus.in_a & bus.in_b;
            OpOr:    alu_res = bus.in_a | bus.in_b;
            OpXor:   alu_res = bus.in_a ^ bus.in_b;
            OpSll:   alu_res = bus.in_a << sh;
            OpSrl:   alu_res = bus.in_a >> sh;
            OpSra:   alu_res = $unsigned($signed(bus.in_a) >>> sh);
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, bus.in_a < bus.in_b};
            OpPassb: alu_res = bus.in_b;
            OpJalr:  alu_res = {sum[XLEN-1:1], 1'b0};
            OpLoad: begin
                alu_res          = sum;
                alu_flags.mem_rd = 1'b1;
            end
            OpStore: begin
                alu_res           = sum;
                alu_flags.reg_wen = 1'b0;
                alu_flags.mem_wr  = 1'b1;
            end
`ifdef YSYX_25020047_EXU_MULDIV_EN
            OpMul, OpMulh, OpMulhu, OpMulhsu, OpDiv, OpDivu, OpRem, OpRemu: begin
            end
`endif
            default: alu_flags = '{reg_wen: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b1};
        endcase
    end

`ifdef YSYX_25020047_EXU_MULDIV_EN
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;

    ysyx_25020047_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clock (clock),
        .rst_n (rst_n),
        .start (md_start),
        .op    (bus.in_op),
        .a     (bus.in_a),
        .b     (bus.in_b),
        .done  (md_done),
        .result(md_result)
    );
`endif

    assign bus.in_ready = (state_q == StIdle) || (state_q == StDone && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        flags_d  = flags_q;
`ifdef YSYX_25020047_EXU_MULDIV_EN
        md_start = 1'b0;
`endif
        if (state_q == StDone && bus.out_ready) state_d = StIdle;
        if (accept) begin
            rd_d     = bus.in_rd;
            state_d  = StDone;
            result_d = alu_res;
            flags_d  = alu_flags;
`ifdef YSYX_25020047_EXU_MULDIV_EN
            if (is_muldiv(bus.in_op)) begin
                md_start = 1'b1;
                state_d  = StBusy;
            end
`endif
        end
`ifdef YSYX_25020047_EXU_MULDIV_EN
        if (state_q == StBusy && md_done) begin
            state_d  = StDone;
            result_d = md_result;
            flags_d  = '{reg_wen: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            rd_q     <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.out_valid   = (state_q == StDone);
    assign bus.out_result  = result_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_reg_wen = flags_q.reg_wen;
    assign bus.out_mem_rd  = flags_q.mem_rd;
    assign bus.out_mem_wr  = flags_q.mem_wr;
    assign bus.out_illegal = flags_q.illegal;

endmodule

// File: tb/tb_ysyx_25020047_exu_mc.sv
// Directed bench for the EXU: reset, ALU ops back-to-back, stall hold, illegal ops, mul/div.
module tb_ysyx_25020047_exu_mc;
    import ysyx_25020047_exu_pkg::*;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ysyx_25020047_exu_mc_if #(.XLEN(32), .RD_W(5)) bus ();

    ysyx_25020047_exu_mc #(
        .XLEN(32),
        .RD_W(5)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // {reg_wen, mem_rd, mem_wr, illegal}
    logic [3:0] fl_obs;
    assign fl_obs = {bus.out_reg_wen, bus.out_mem_rd, bus.out_mem_wr, bus.out_illegal};

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [3:0]  fl;
    } vec_t;

    vec_t alu_v [12];
    vec_t md_v  [11];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_rd = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.out_result); end
        n_cmp++; if (bus.out_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got %h want 0", bus.out_rd); end
        n_cmp++; if (fl_obs !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", fl_obs); end
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_add();
        drive(OpAdd, 32'h7FFF_FFFF, 32'h1, 5'd3);
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h want 80000000", bus.out_result); end
        n_cmp++; if (fl_obs !== 4'b1000) begin n_err++; $display("FAIL add_flags got %b want 1000", fl_obs); end
        n_cmp++; if (bus.out_rd !== 5'd3) begin n_err++; $display("FAIL add_rd got %0d want 3", bus.out_rd); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_drop got %b want 0", bus.out_valid); end
    endtask

    task automatic test_store_stall();
        drive(OpStore, 32'h8000_0000, 32'h10, 5'd7);
        bus.out_ready = 1'b0;
        step();
        // next bundle waits while the store result is stalled
        drive(OpAdd, 32'd1, 32'd2, 5'd9);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL st_valid[%0d] got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_result !== 32'h8000_0010) begin n_err++; $display("FAIL st_result[%0d] got %h want 80000010", i, bus.out_result); end
            n_cmp++; if (fl_obs !== 4'b0010) begin n_err++; $display("FAIL st_flags[%0d] got %b want 0010", i, fl_obs); end
            n_cmp++; if (bus.out_rd !== 5'd7) begin n_err++; $display("FAIL st_rd[%0d] got %0d want 7", i, bus.out_rd); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL st_ready[%0d] got %b want 0", i, bus.in_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL st_release_ready got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3 || bus.out_rd !== 5'd9) begin n_err++; $display("FAIL st_next got v%b %h rd%0d want v1 00000003 rd9", bus.out_valid, bus.out_result, bus.out_rd); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL st_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        alu_v[0]  = '{OpSub,   32'd5,        32'd7,        32'hFFFF_FFFE, 4'b1000};
        alu_v[1]  = '{OpAnd,   32'hF0F0,     32'hFF00,     32'h0000_F000, 4'b1000};
        alu_v[2]  = '{OpOr,    32'hF0F0,     32'h0F0F,     32'h0000_FFFF, 4'b1000};
        alu_v[3]  = '{OpXor,   32'hFF,       32'h0F,       32'h0000_00F0, 4'b1000};
        alu_v[4]  = '{OpSll,   32'd1,        32'h24,       32'h0000_0010, 4'b1000};
        alu_v[5]  = '{OpSrl,   32'h8000_0000, 32'h1F,      32'h0000_0001, 4'b1000};
        alu_v[6]  = '{OpSra,   32'h8000_0000, 32'h21,      32'hC000_0000, 4'b1000};
        alu_v[7]  = '{OpSlt,   32'hFFFF_FFFF, 32'd1,       32'h0000_0001, 4'b1000};
        alu_v[8]  = '{OpSltu,  32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 4'b1000};
        alu_v[9]  = '{OpPassb, 32'd5,        32'h1234_5000, 32'h1234_5000, 4'b1000};
        alu_v[10] = '{OpJalr,  32'h1001,     32'h2,        32'h0000_1002, 4'b1000};
        alu_v[11] = '{OpLoad,  32'h100,      32'hFFFF_FFFC, 32'h0000_00FC, 4'b1100};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(alu_v[i].op, alu_v[i].a, alu_v[i].b, 5'(i + 1));
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready); end
            step();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_result !== alu_v[i].exp) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", i, bus.out_result, alu_v[i].exp); end
            n_cmp++; if (fl_obs !== alu_v[i].fl) begin n_err++; $display("FAIL b2b_flags[%0d] got %b want %b", i, fl_obs, alu_v[i].fl); end
            n_cmp++; if (bus.out_rd !== 5'(i + 1)) begin n_err++; $display("FAIL b2b_rd[%0d] got %0d want %0d", i, bus.out_rd, i + 1); end
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        drive(5'd31, 32'h1234, 32'h5678, 5'd4);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL ill_result got %h want 0", bus.out_result); end
        n_cmp++; if (fl_obs !== 4'b0001) begin n_err++; $display("FAIL ill_flags got %b want 0001", fl_obs); end
        step();
    endtask

`ifdef YSYX_25020047_EXU_MULDIV_EN
    task automatic test_muldiv();
        int k;
        md_v[0]  = '{OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1000};
        md_v[1]  = '{OpRemu,   32'd5,         32'd0,         32'd5,         4'b1000};
        md_v[2]  = '{OpDivu,   32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1000};
        md_v[3]  = '{OpMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000};
        md_v[4]  = '{OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000};
        md_v[5]  = '{OpMul,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b1000};
        md_v[6]  = '{OpDiv,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 4'b1000};
        md_v[7]  = '{OpRem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 4'b1000};
        md_v[8]  = '{OpMulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 4'b1000};
        md_v[9]  = '{OpDiv,    32'd7,         32'd0,         32'hFFFF_FFFF, 4'b1000};
        md_v[10] = '{OpRem,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 4'b1000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(md_v[i].op, md_v[i].a, md_v[i].b, 5'd12);
            step();
            bus.in_valid = 1'b0;
            n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL md_busy[%0d] got ready %b valid %b want 0 0", i, bus.in_ready, bus.out_valid); end
            k = 1;
            step();
            while (bus.out_valid !== 1'b1 && k < 100) begin
                step();
                k++;
            end
            n_cmp++; if (k !== 33) begin n_err++; $display("FAIL md_latency[%0d] got %0d want 33", i, k); end
            n_cmp++; if (bus.out_result !== md_v[i].exp) begin n_err++; $display("FAIL md_result[%0d] got %h want %h", i, bus.out_result, md_v[i].exp); end
            n_cmp++; if (fl_obs !== md_v[i].fl) begin n_err++; $display("FAIL md_flags[%0d] got %b want %b", i, fl_obs, md_v[i].fl); end
            step();
        end
    endtask

    task automatic test_reset_busy();
        bus.out_ready = 1'b1;
        drive(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rb_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rb_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_result !== 32'h0 || bus.out_rd !== 5'd0) begin n_err++; $display("FAIL rb_out got %h rd%0d want 0 rd0", bus.out_result, bus.out_rd); end
        step();
        rst_n = 1'b1;
        repeat (40) step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rb_discard got %b want 0", bus.out_valid); end
    endtask
`else
    task automatic test_muldiv_disabled();
        bus.out_ready = 1'b1;
        drive(OpMul, 32'd3, 32'd4, 5'd2);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL nomd_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (fl_obs !== 4'b0001) begin n_err++; $display("FAIL nomd_flags got %b want 0001", fl_obs); end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL nomd_result got %h want 0", bus.out_result); end
        drive(OpDivu, 32'd9, 32'd3, 5'd2);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || fl_obs !== 4'b0001) begin n_err++; $display("FAIL nomd_divu got v%b %b want v1 0001", bus.out_valid, fl_obs); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_store_stall();
        test_back_to_back();
        test_illegal();
`ifdef YSYX_25020047_EXU_MULDIV_EN
        test_muldiv();
        test_reset_busy();
`else
        test_muldiv_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
